// File: rtl/alu_cmd_sequencer_if.sv
// Byte-serial command channel and result channel between the input bus and the ALU sequencer.
// The sequencer takes the slave side; whoever feeds commands and consumes results takes the master side.
interface alu_cmd_sequencer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Sequences opcode/A/B command bytes onto the registered inputs of a combinational ALU,
// waits ALU_LAT cycles, and hands the sampled result back over a valid/ready channel.
module alu_cmd_sequencer #(
    parameter int WIDTH   = 8,
    parameter int SEL_W   = 2,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    alu_cmd_sequencer_if.slave bus,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [SEL_W-1:0]  alu_s,
    input  logic [WIDTH-1:0]  alu_result,
    output logic              busy,
    output logic [7:0]        op_count
);
    typedef enum logic [2:0] {
        GET_OP,
        GET_A,
        GET_B,
        EXEC,
        RESP
    } state_t;

    localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT - 1);

    state_t           state;
    state_t           state_next;
    logic [3:0]       lat_cnt;
    logic [WIDTH-1:0] out_data_r;
    logic             in_ready_c;
    logic             out_valid_c;
    logic             load_s;
    logic             load_a;
    logic             load_b;
    logic             load_cnt;
    logic             capture;
    logic             retire;

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = out_data_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= GET_OP;
        end else begin
            state <= state_next;
        end
    end

    // Operand, select and result registers only move on their own load strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_s      <= '0;
            out_data_r <= '0;
            op_count   <= '0;
            lat_cnt    <= '0;
        end else begin
            if (load_s) alu_s <= bus.in_data[SEL_W-1:0];
            if (load_a) alu_a <= bus.in_data;
            if (load_b) alu_b <= bus.in_data;
            if (load_cnt) begin
                lat_cnt <= LAT_LOAD;
            end else if (state == EXEC && lat_cnt != 4'd0) begin
                lat_cnt <= lat_cnt - 4'd1;
            end
            if (capture) out_data_r <= alu_result;
            if (retire)  op_count   <= op_count + 8'd1;
        end
    end

    always_comb begin
        state_next  = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        busy        = 1'b1;
        load_s      = 1'b0;
        load_a      = 1'b0;
        load_b      = 1'b0;
        load_cnt    = 1'b0;
        capture     = 1'b0;
        retire      = 1'b0;
        case (state)
            GET_OP: begin
                in_ready_c = 1'b1;
                busy       = 1'b0;
                if (bus.in_valid) begin
                    load_s = 1'b1;
                    // Loading here serves the reuse path; a full command reloads on B.
                    load_cnt   = 1'b1;
                    state_next = bus.in_data[WIDTH-1] ? EXEC : GET_A;
                end
            end
            GET_A: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    load_a     = 1'b1;
                    state_next = GET_B;
                end
            end
            GET_B: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    load_b     = 1'b1;
                    load_cnt   = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (lat_cnt == 4'd0) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    retire     = 1'b1;
                    state_next = GET_OP;
                end
            end
            default: state_next = GET_OP;
        endcase
    end
endmodule
